// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: parameter defaults and
// the fetch control state encoding.
package fetch_pkg;

  localparam int unsigned PcWDef    = 3;
  localparam int unsigned InstrWDef = 16;
  localparam int unsigned DepthDef  = 4;

  // Fetch control states: RUN issues fetches, SQUASH drops a stale response,
  // HALT stops issuing but keeps draining.
  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSquash = 2'd1,
    StHalt   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset (pointers/count only)
//   flush         - empties the FIFO on the next edge; wins over push/pop
//   push, wdata   - write request and data; ignored when full without a pop
//   pop           - read request; a no-op when empty
//   rdata         - head entry
//   full, empty   - status flags
//   count         - number of valid entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = PcWDef + InstrWDef,
  parameter int unsigned DEPTH = DepthDef
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is allowed only when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-cycle-latency reads to instruction
// memory, buffers responses tagged with their PC in a prefetch FIFO, and hands
// them to decode with a valid/ready handshake. Supports redirect and halt.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   imem_req, imem_addr      - memory read strobe and address
//   imem_rdata               - read data, valid one cycle after imem_req
//   redirect, redirect_pc    - jump request and its target PC
//   halt                     - stop issuing new fetches
//   instr_valid/ready        - decode handshake
//   instr_data, instr_pc     - queue-head instruction and its PC
//   occupancy                - number of queued instructions
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W    = PcWDef,
  parameter int unsigned INSTR_W = InstrWDef,
  parameter int unsigned DEPTH   = DepthDef
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  input  logic                   halt,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_W-1:0]     instr_data,
  output logic [PC_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = PC_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              inflight_q;
  logic [PC_W-1:0]   inflight_pc_q;

  logic              q_push, q_pop, q_flush, q_full, q_empty, room;
  logic [EW-1:0]     q_wdata, q_rdata;
  logic [CW-1:0]     q_count;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (q_flush),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign q_wdata     = {inflight_pc_q, imem_rdata};
  assign instr_valid = !q_empty;
  // Gate the head so unreset storage never shows on the outputs.
  assign instr_data  = q_empty ? '0 : q_rdata[INSTR_W-1:0];
  assign instr_pc    = q_empty ? '0 : q_rdata[EW-1:INSTR_W];
  assign occupancy   = q_count;
  assign imem_addr   = fetch_pc_q;

  // Space check counts the in-flight response and credits a same-cycle pop.
  always_comb begin
    room = 1'b0;
    if (!inflight_q) room = !q_full || q_pop;
    else             room = (int'(q_count) + 1 - int'(q_pop)) < int'(DEPTH);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StRun;
    else      state_q <= state_d;
  end

  // Next-state logic; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = StSquash;
    end else begin
      unique case (state_q)
        StRun:    if (halt) state_d = StHalt;
        StSquash: state_d = halt ? StHalt : StRun;
        StHalt:   if (!halt) state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
  end

  // Outputs and FIFO controls.
  always_comb begin
    q_pop   = instr_ready && !q_empty;
    q_flush = redirect;
    // The in-flight response lands unless it belongs to a squashed stream.
    q_push  = inflight_q && (state_q != StSquash) && !redirect;
    // rst keeps the strobe low while reset is held.
    imem_req = rst && (state_q == StRun) && !redirect && !halt && room;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)      fetch_pc_d = redirect_pc;
    else if (imem_req) fetch_pc_d = fetch_pc_q + PC_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= imem_req;
      if (imem_req) inflight_pc_q <= fetch_pc_q;
    end
  end

endmodule
